// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: round-robin A/B grants plus a zeroing sweep.
// Define REGFILE_ARB_FIXED_PRI_EN to make A win every conflict (no pointer).
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic [NREG-1:0]   wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic arb_ok;
  logic sel_a;
  logic sel_b;

  // Row 0 is hard-wired zero, so its enable is never raised.
  function automatic logic [NREG-1:0] row_en(
    input logic [ADDR_W-1:0] addr
  );
    logic [NREG-1:0] r;
    r = '0;
    if (addr != '0)
      r[addr] = 1'b1;
    return r;
  endfunction

`ifdef REGFILE_ARB_FIXED_PRI_EN
  assign sel_a = a_req;
  assign sel_b = b_req & ~a_req;
`else
  logic last_b_q, last_b_d;

  assign sel_a = a_req & (~b_req | last_b_q);
  assign sel_b = b_req & (~a_req | ~last_b_q);

  always_comb begin
    last_b_d = last_b_q;
    if (a_gnt)
      last_b_d = 1'b0;
    else if (b_gnt)
      last_b_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      last_b_q <= 1'b1;
    else
      last_b_q <= last_b_d;
  end
`endif

  assign arb_ok = (state_q == IDLE) & ~sweep_start;
  assign a_gnt  = arb_ok & sel_a;
  assign b_gnt  = arb_ok & sel_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = SWEEP;
          cnt_d   = ADDR_W'(1);
        end else begin
          unique case (1'b1)
            a_gnt: begin
              wr_en_d   = row_en(a_addr);
              wr_addr_d = a_addr;
              wr_data_d = a_data;
            end
            b_gnt: begin
              wr_en_d   = row_en(b_addr);
              wr_addr_d = b_addr;
              wr_data_d = b_data;
            end
            default: ;
          endcase
        end
      end
      SWEEP: begin
        wr_en_d   = row_en(cnt_q);
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(NREG - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign sweep_busy = (state_q == SWEEP);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between two requesters (A: processor writeback, B: game-logic side port) and sequences a zeroing sweep across the register file. Sits in front of the register array and drives the per-row write enables, the write address and the write data that feed the storage flops. Grants are round-robin, writes reach the array one cycle after grant, and register 0 is never written.

## Interface
Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, register address width
- NREG, 32, number of registers; must equal 2**ADDR_W

Ports:
- clk  in  1  clock; all state changes on rising edge
- clr_n  in  1  reset, asynchronous, active-low
- a_req  in  1  requester A wants to write this cycle
- a_addr  in  ADDR_W  A target register
- a_data  in  DATA_W  A write data
- a_gnt  out  1  A's write accepted this cycle (combinational)
- b_req  in  1  requester B wants to write this cycle
- b_addr  in  ADDR_W  B target register
- b_data  in  DATA_W  B write data
- b_gnt  out  1  B's write accepted this cycle (combinational)
- sweep_start  in  1  request a zeroing sweep of registers 1..NREG-1
- sweep_busy  out  1  sweep in progress; no grants issued
- wr_en  out  NREG  one-hot (or all-zero) row write enables, registered
- wr_addr  out  ADDR_W  address of the current write, registered
- wr_data  out  DATA_W  data of the current write, registered

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE and SWEEP.
- While clr_n is low, the block holds:
  - state IDLE, sweep counter 0, round-robin pointer "last = B" (so A wins first).
  - wr_en, wr_addr, wr_data and sweep_busy all 0.
- IDLE:
  - If sweep_start is high, go to SWEEP with counter = 1. No grant is issued that cycle, even if a_req or b_req is high.
  - Otherwise, one request is granted per cycle:
    - If only one requester is asserting, it wins.
    - If both are asserting, the requester not granted last wins.
    - The pointer updates only when a grant is issued.
  - The granted requester's addr/data are registered into wr_addr/wr_data. wr_en = onehot(addr), except addr 0, which gives wr_en = 0. The grant itself is still issued and consumed for addr 0.
  - With no grant: wr_en = 0, wr_addr and wr_data hold their previous values.
- SWEEP:
  - Each cycle registers wr_en = onehot(counter), wr_addr = counter, wr_data = 0, then increments the counter.
  - When the registered counter equals NREG-1, return to IDLE.
  - sweep_start is ignored during a sweep.
  - a_gnt and b_gnt are 0 during a sweep. Requesters must hold req/addr/data until granted; requests are never dropped silently.
- sweep_busy = (state == SWEEP).
- Reset mid-sweep aborts the sweep immediately. Registers not yet swept keep their contents; the arbiter does not resume the sweep.

## Timing
- a_gnt and b_gnt are combinational from the req inputs, state, sweep_start and the pointer. No combinational path from any input to wr_*.
- Write latency is 1: a grant in cycle n produces wr_en/wr_addr/wr_data in cycle n+1, and the array captures them at the end of cycle n+1.
- wr_en is high for exactly one cycle per accepted write. Back-to-back grants give back-to-back writes.
- Sweep timeline, with sweep_start sampled at edge k:
  - sweep_busy is high from edge k to edge k+NREG-1, which is NREG-1 cycles.
  - wr_en[1] is visible after edge k+1; wr_en[NREG-1] is visible after edge k+NREG-1.
  - A grant is possible in the cycle following edge k+NREG-1.
- Total sweep length is NREG-1 write cycles with no gaps.

## Configuration
- REGFILE_ARB_FIXED_PRI_EN defined: A always wins a conflict and the round-robin pointer is removed. B is granted only when a_req is low.
- REGFILE_ARB_FIXED_PRI_EN undefined: round-robin behaviour as described above.
- Sweep and register-0 handling are identical in both builds.

## Test plan
- Reset release, then a_req=b_req=1 held, addrs 3/7, data 0xA/0xB, for 4 cycles -> grants A,B,A,B; wr_en = bit3, bit7, bit3, bit7 each one cycle later. With REGFILE_ARB_FIXED_PRI_EN defined: A,A,A,A.
- a_req with a_addr=0, data 0xFFFF_FFFF -> a_gnt=1; next cycle wr_en=0 and the pointer records A.
- sweep_start pulse in IDLE with b_req=1 held -> b_gnt=0 for 32 cycles (the sweep_start cycle plus 31 busy cycles); wr_en walks bit1..bit31 with wr_data=0; b_gnt=1 the first cycle after sweep_busy falls.
- sweep_start re-pulsed during a sweep -> no restart; exactly 31 wr_en pulses total.
- clr_n low for 1 cycle at sweep counter 10 -> wr_en, wr_addr, wr_data, sweep_busy are 0 immediately, asynchronously; the state afterwards is IDLE; registers 10..31 are not written.
- Single b_req, addr 31, data 0x1234 -> b_gnt the same cycle; next cycle wr_en=bit31, wr_addr=31, wr_data=0x1234; then wr_en=0.
